hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard unit for the pipelined MIPS core, sitting beside the ID stage. It holds an internal scoreboard of in-flight register writes for the stages after ID, ages their Tnew each cycle, and compares them against the Tuse of the two ID source operands. From that comparison it produces the ID stall, the ID-stage forwarding selects used for branch compares, and a multiply/divide busy interlock.

## Interface
Parameters:
- REG_AW, 5, register address width
- TW, 2, Tnew/Tuse field width
- DEPTH, 3, number of tracked post-ID stages (slot 0 = EX, slot 1 = MEM, slot 2 = WB)
- MD_LAT, 5, multiply busy cycles
- DIV_LAT, 10, divide busy cycles
- SW, 2, forwarding select width; must satisfy 2^SW ≥ DEPTH+1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register addresses
- id_use_rs, id_use_rt  in  1  source actually read
- id_tuse_rs, id_tuse_rt  in  TW  cycles until the value is needed (0 = needed in ID)
- id_wa  in  REG_AW  destination register (0 = no write)
- id_tnew  in  TW  Tnew of the ID instruction on entry to EX
- id_md_start  in  1  ID instruction is mult/div
- id_md_div  in  1  with id_md_start: divide (else multiply)
- id_md_use  in  1  ID instruction reads HI/LO or starts mult/div
- stall  out  1  freeze PC/IF-ID, insert bubble into EX
- fwd_rs_sel, fwd_rt_sel  out  SW  ID operand source: 0 = register file, k+1 = slot k
- md_busy  out  1  mult/div unit occupied

## Operation
- Scoreboard slot k holds {wa, tnew}. Reset value: all slots wa=0, tnew=0.
- Each rising edge:
  - slot[k+1] ← slot[k] with tnew decremented, saturating at 0.
  - slot[0] ← {id_wa, id_tnew} if id_valid && !stall; otherwise bubble {0,0}. The last slot's old content is discarded.
- Per source s (rs or rt), evaluated combinationally:
  - A slot matches when use_s=1, slot.wa == s, and s ≠ 0.
  - Only the lowest-index matching slot (the youngest producer) counts.
  - hazard_s = match && slot.tnew > tuse_s. Compare unsigned at TW+1 bits.
  - fwd_s_sel = k+1 if the youngest match has tnew == 0; otherwise 0.
- MDU interlock:
  - md_cnt resets to 0.
  - On accept (id_valid && id_md_start && !stall), md_cnt loads DIV_LAT if id_md_div, else MD_LAT.
  - Otherwise md_cnt decrements while nonzero.
  - md_busy = (md_cnt ≠ 0).
- stall = id_valid && (hazard_rs || hazard_rt || (id_md_use && md_busy)). Reset value 0.
- Precedence rules:
  - A stall never blocks aging; bubbles still enter slot 0.
  - A load into md_cnt wins over the decrement in the same cycle.

## Timing
- stall, fwd_*_sel and md_busy are combinational from the ID inputs and registered state, valid in the same cycle.
- Scoreboard and md_cnt update on the rising clk edge. reset low clears them immediately, independent of clk.
- A producer with Tnew=t at EX entry can satisfy a Tuse=0 consumer issued d cycles later once t−d ≤ 0.
- Mult followed directly by mfhi stalls exactly MD_LAT cycles; div stalls DIV_LAT cycles.
- When reset is asserted mid-stall, stall drops to 0 at once and the pipeline restarts with an empty scoreboard.

## Configuration
- HAZ_FWD_EN defined (forwarding enabled):
  - Behaviour is as described above.
- HAZ_FWD_EN undefined (no forwarding):
  - fwd_rs_sel and fwd_rt_sel are tied to 0.
  - Any match in slots 0..DEPTH−2 stalls, regardless of tnew.
  - The WB slot never stalls, because the register file writes through.

## Test plan
- Zero-target matching:
  - Stimulus: lw $8 (tnew=2) in EX, then beq $8,$9 in ID with tuse=0.
  - Response: stall=1 for 2 cycles, then fwd_rs_sel=3 (WB) and stall=0.
  - Repeat with id_rs=0 and wa=0: stall stays 0 and fwd_rs_sel stays 0.
- ALU to branch:
  - Stimulus: addu $3 (tnew=1) followed by beq $3 (tuse=0).
  - Response: 1 stall cycle, then fwd_rs_sel=2 (MEM).
  - Variant: addu $3 followed by addu using $3 with tuse=1: no stall, fwd_rs_sel=0.
- Youngest-producer priority:
  - Stimulus: $5 written in slot 0 (tnew=0) and in slot 2.
  - Response: fwd_rt_sel=1.
- MDU interlock:
  - Stimulus: div accepted, then mflo in ID.
  - Response: md_busy=1 and stall=1 for exactly 10 cycles.
  - Variant: reset asserted at cycle 4 clears md_busy and stall immediately.
- Build without HAZ_FWD_EN:
  - Stimulus: addu $3 followed by addu using $3 (tuse=1).
  - Response: stall=1 for 2 cycles and fwd selects always 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage scoreboard hazard unit producing stall, branch-operand forwarding and a mult/div interlock.
// Define HAZ_FWD_EN for forwarding; without it any match outside the WB slot stalls.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TW      = 2,
    parameter int DEPTH   = 3,
    parameter int MD_LAT  = 5,
    parameter int DIV_LAT = 10,
    parameter int SW      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [TW-1:0]     id_tuse_rs,
    input  logic [TW-1:0]     id_tuse_rt,
    input  logic [REG_AW-1:0] id_wa,
    input  logic [TW-1:0]     id_tnew,
    input  logic              id_md_start,
    input  logic              id_md_div,
    input  logic              id_md_use,
    output logic              stall,
    output logic [SW-1:0]     fwd_rs_sel,
    output logic [SW-1:0]     fwd_rt_sel,
    output logic              md_busy
);
    localparam int CW = $clog2((DIV_LAT > MD_LAT ? DIV_LAT : MD_LAT) + 1);

    logic [REG_AW-1:0] sb_wa   [DEPTH];
    logic [TW-1:0]     sb_tnew [DEPTH];
    logic [CW-1:0]     md_cnt;
    logic [REG_AW-1:0] src [2];
    logic [1:0]        use_s;
    logic [1:0]        hz;
    logic [SW-1:0]     sel [2];
    logic              accept;

    assign src[0] = id_rs;
    assign src[1] = id_rt;
    assign use_s  = {id_use_rt, id_use_rs};

`ifdef HAZ_FWD_EN
    logic [TW-1:0] tuse [2];
    assign tuse[0] = id_tuse_rs;
    assign tuse[1] = id_tuse_rt;
`else
    logic unused_tuse;
    assign unused_tuse = ^{id_tuse_rs, id_tuse_rt};
`endif

    // Scan oldest to youngest so the lowest-index match overrides.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hz[s]  = 1'b0;
            sel[s] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (use_s[s] && src[s] != '0 && sb_wa[k] == src[s]) begin
`ifdef HAZ_FWD_EN
                    hz[s]  = {1'b0, sb_tnew[k]} > {1'b0, tuse[s]};
                    sel[s] = (sb_tnew[k] == '0) ? SW'(k + 1) : '0;
`else
                    hz[s]  = k < DEPTH - 1;
                    sel[s] = '0;
`endif
                end
            end
        end
    end

    assign md_busy    = md_cnt != '0;
    assign stall      = id_valid && (hz[0] || hz[1] || (id_md_use && md_busy));
    assign accept     = id_valid && !stall;
    assign fwd_rs_sel = sel[0];
    assign fwd_rt_sel = sel[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_wa   <= '{default: '0};
            sb_tnew <= '{default: '0};
            md_cnt  <= '0;
        end else begin
            sb_wa[0]   <= accept ? id_wa : '0;
            sb_tnew[0] <= accept ? id_tnew : '0;
            for (int k = 1; k < DEPTH; k++) begin
                sb_wa[k]   <= sb_wa[k-1];
                sb_tnew[k] <= sb_tnew[k-1] - TW'(sb_tnew[k-1] != '0);
            end
            md_cnt <= (accept && id_md_start) ? (id_md_div ? CW'(DIV_LAT) : CW'(MD_LAT))
                                              : md_cnt - CW'(md_busy);
        end
    end
endmodule
